// File: rtl/fir_mac_serial.sv
// fir_mac_serial: time-multiplexed FIR tap engine.
// Accepts one sample through a valid/ready handshake and shifts it into a
// private TAPS-deep delay line. It then runs one multiply-accumulate per clock
// over all taps and holds the formatted result until the sink takes it.
// Optional build macro FIR_ROUND_SAT_EN: when defined, the output is rounded
// half up and saturated. When undefined, the output is truncated toward -inf
// and wraps.
module fir_mac_serial #(
  parameter int N         = 16,
  parameter int CW        = 16,
  parameter int TAPS      = 4,
  parameter int OUT_SHIFT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [N-1:0]  data_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TAPS*CW-1:0]   coeff_flat,
  output logic signed [N-1:0]  data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int IW = $clog2(TAPS);
  localparam int PW = N + CW;
  localparam int AW = N + CW + $clog2(TAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  state_t              state;
  state_t              state_next;
  logic signed [N-1:0] x [TAPS];
  logic signed [CW-1:0] c [TAPS];
  logic signed [AW-1:0] acc;
  logic [IW-1:0]       idx;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sum;
  logic signed [N-1:0] fmt_val;

  // Current tap product and the running sum including it (exact, no overflow)
  always_comb begin
    prod = PW'(x[idx]) * PW'(c[idx]);
    sum  = acc + AW'(prod);
  end

`ifdef FIR_ROUND_SAT_EN
  localparam logic signed [AW-1:0] HALF    = AW'(64'sd1 << (OUT_SHIFT - 1));
  localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 << (N - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(64'sd1 << (N - 1)));

  logic signed [AW-1:0] rounded;
  logic signed [AW-1:0] shifted;

  // Round half up, scale down, then clamp into the N-bit signed range
  always_comb begin
    rounded = sum + HALF;
    shifted = rounded >>> OUT_SHIFT;
    if (shifted > SAT_MAX) begin
      fmt_val = {1'b0, {(N-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      fmt_val = {1'b1, {(N-1){1'b0}}};
    end else begin
      fmt_val = shifted[N-1:0];
    end
  end
`else
  // Plain bit-select: floor division by 2^OUT_SHIFT, upper bits wrap away
  always_comb begin
    fmt_val = sum[OUT_SHIFT+N-1:OUT_SHIFT];
  end
`endif

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept -> walk all taps -> wait for the sink
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)        state_next = MAC;
      MAC:     if (idx == LAST_IDX) state_next = HOLD;
      HOLD:    if (out_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready is held low during reset
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: in_ready = reset;
      MAC:  busy = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: delay line and coefficient capture on accept, MAC walk, result latch
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
      acc      <= '0;
      idx      <= '0;
      data_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x[0] <= data_in;
            for (int k = 1; k < TAPS; k++) begin
              x[k] <= x[k-1];
            end
            for (int k = 0; k < TAPS; k++) begin
              c[k] <= $signed(coeff_flat[k*CW +: CW]);
            end
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= sum;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            data_out <= fmt_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_serial.sv
// tb_fir_mac_serial: directed bench for fir_mac_serial (N=16, CW=16, TAPS=4,
// OUT_SHIFT=15). A reference model computes each expected output when a sample
// is accepted and queues it. The queue is popped when the DUT presents data.
// Honours FIR_ROUND_SAT_EN the same way as the design.
module tb_fir_mac_serial;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] data_in;
  logic               in_valid;
  logic               in_ready;
  logic [63:0]        coeff_flat;
  logic signed [15:0] data_out;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0]        exp_q [$];
  logic signed [15:0] mx [4];

`ifdef FIR_ROUND_SAT_EN
  localparam logic [15:0] IMP_EXP [4] = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
  localparam logic [15:0] OVF_EXP [4] = '{16'h7FFE, 16'h7FFF, 16'h7FFF, 16'h7FFF};
`else
  localparam logic [15:0] IMP_EXP [4] = '{16'h3FFF, 16'h1FFF, 16'h0FFF, 16'h07FF};
  localparam logic [15:0] OVF_EXP [4] = '{16'h7FFE, 16'hFFFC, 16'h7FFA, 16'hFFF8};
`endif

  localparam logic [15:0] B2B_SAMP [8] = '{16'h1234, 16'h7FFF, 16'h8000, 16'h0F0F,
                                           16'hF0F0, 16'h0001, 16'hFFFF, 16'h4000};

  fir_mac_serial #(.N(16), .CW(16), .TAPS(4), .OUT_SHIFT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coeff_flat (coeff_flat),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fmtModel(input longint s);
    longint t;
`ifdef FIR_ROUND_SAT_EN
    t = (s + 64'sd16384) >>> 15;
    if (t > 64'sd32767)  t = 64'sd32767;
    if (t < -64'sd32768) t = -64'sd32768;
`else
    t = s >>> 15;
`endif
    return t[15:0];
  endfunction

  task automatic modelAccept(input logic [15:0] s, input logic [63:0] coefs);
    longint             total;
    logic signed [15:0] cv;
    for (int k = 3; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = s;
    total = 0;
    for (int k = 0; k < 4; k++) begin
      cv = coefs[k*16 +: 16];
      total += longint'(mx[k]) * longint'(cv);
    end
    exp_q.push_back(fmtModel(total));
  endtask

  task automatic modelReset();
    for (int k = 0; k < 4; k++) mx[k] = '0;
    exp_q.delete();
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b0;
    repeat (cycles) step();
    reset = 1'b1;
    modelReset();
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] s, input logic [63:0] coefs);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    checkOutput("ready_wait", {31'b0, in_ready}, 32'd1);
    data_in    = s;
    coeff_flat = coefs;
    in_valid   = 1'b1;
    modelAccept(s, coefs);
    step();
    in_valid = 1'b0;
  endtask

  task automatic popCheck(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h with no expected value queued", tag, data_out);
    end else begin
      e = exp_q.pop_front();
      checkOutput(tag, {16'b0, data_out}, {16'b0, e});
    end
  endtask

  task automatic collectOutput(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, 32'd4);
    popCheck(tag);
  endtask

  initial begin
    logic [15:0] held;
    int          nacc;
    int          nout;
    int          last;
    logic        took;

    reset      = 1'b0;
    data_in    = '0;
    in_valid   = 1'b0;
    coeff_flat = '0;
    out_ready  = 1'b1;
    modelReset();

    // Reset held for three edges
    repeat (3) step();
    checkOutput("rst_data_out",  {16'b0, data_out}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_in_ready",  {31'b0, in_ready}, 32'd0);
    checkOutput("rst_busy",      {31'b0, busy}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic single tap
    applyStimulus(16'h2000, {16'h0000, 16'h0000, 16'h0000, 16'h4000});
    collectOutput("basic");
    checkOutput("basic_const", {16'b0, data_out}, 32'h1000);
    step();
    checkOutput("basic_idle", {31'b0, out_valid}, 32'd0);

    // Impulse response from a clean delay line
    doReset(2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus((i == 0) ? 16'h7FFF : 16'h0000,
                    {16'h0800, 16'h1000, 16'h2000, 16'h4000});
      collectOutput("impulse");
      checkOutput("impulse_const", {16'b0, data_out}, {16'b0, IMP_EXP[i]});
      step();
    end

    // Overflow: full-scale samples and coefficients
    doReset(2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'h7FFF, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF});
      collectOutput("overflow");
      checkOutput("overflow_const", {16'b0, data_out}, {16'b0, OVF_EXP[i]});
      step();
    end

    // Backpressure: sink stalls while the source keeps offering samples
    out_ready = 1'b0;
    applyStimulus(16'h1234, {16'h1000, 16'hE000, 16'h3000, 16'h2000});
    collectOutput("bp_first");
    held = data_out;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      data_in  = 16'($urandom);
      step();
      checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_data_hold", {16'b0, data_out}, {16'b0, held});
      checkOutput("bp_in_ready",  {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checkOutput("bp_release_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(16'h0100, {16'h1000, 16'hE000, 16'h3000, 16'h2000});
    collectOutput("bp_after");
    step();

    // Reset during the second MAC cycle
    applyStimulus(16'h5555, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF});
    step();
    checkOutput("mid_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    checkOutput("mid_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mid_data_out",  {16'b0, data_out}, 32'd0);
    checkOutput("mid_busy_idle", {31'b0, busy}, 32'd0);
    reset = 1'b1;
    modelReset();
    #1;
    applyStimulus(16'h2000, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h4000});
    collectOutput("mid_after");
    checkOutput("mid_after_const", {16'b0, data_out}, 32'h1000);
    step();

    // Back-to-back with in_valid and out_ready held high
    coeff_flat = {16'h0800, 16'hF000, 16'h2000, 16'h1000};
    data_in    = B2B_SAMP[0];
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    nacc = 0;
    nout = 0;
    last = 0;
    for (int cyc = 0; cyc < 100 && (nacc < 8 || nout < 8); cyc++) begin
      took = 1'b0;
      checkOutput("b2b_ready_in_busy", {31'b0, in_ready & busy}, 32'd0);
      if (in_ready && in_valid) begin
        modelAccept(data_in, coeff_flat);
        if (nacc > 0) checkOutput("b2b_spacing", cyc - last, 32'd6);
        last = cyc;
        nacc++;
        took = 1'b1;
      end
      if (out_valid) begin
        popCheck("b2b_out");
        nout++;
      end
      step();
      if (took) begin
        if (nacc == 8) in_valid = 1'b0;
        else           data_in  = B2B_SAMP[nacc];
      end
    end
    checkOutput("b2b_accepts", nacc, 32'd8);
    checkOutput("b2b_outputs", nout, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
